// File: rtl/box_pkg.sv
// Shared types for the box compositor: per-box configuration record and default widths.
package box_pkg;

    localparam int BOX_COORD_W = 10;
    localparam int BOX_COLOR_W = 12;

    typedef struct packed {
        logic [BOX_COORD_W-1:0] x;
        logic [BOX_COORD_W-1:0] y;
        logic [BOX_COORD_W-1:0] w;
        logic [BOX_COORD_W-1:0] h;
        logic [BOX_COLOR_W-1:0] color;
        logic                   en;
    } box_cfg_t;

    localparam box_cfg_t BOX_CFG_RESET = '0;

endpackage

// File: rtl/box_hit_cell.sv
// One box's stage-1 hit test: registered inside-rectangle compare for the current pixel.
module box_hit_cell #(
    parameter int COORD_W = 10
) (
    input  logic               clk,
    input  logic               i_reset,
    input  logic [COORD_W-1:0] i_x_pix,
    input  logic [COORD_W-1:0] i_y_pix,
    input  logic               i_pix_valid,
    input  logic [COORD_W-1:0] i_box_x,
    input  logic [COORD_W-1:0] i_box_y,
    input  logic [COORD_W-1:0] i_box_w,
    input  logic [COORD_W-1:0] i_box_h,
    input  logic               i_box_en,
    output logic               o_hit
);

    logic [COORD_W:0] w_x_end;
    logic [COORD_W:0] w_y_end;
    logic             w_hit;
    logic             r_hit;

    // One extra bit keeps boxes hanging off the right/bottom edge from wrapping to 0.
    assign w_x_end = {1'b0, i_box_x} + {1'b0, i_box_w};
    assign w_y_end = {1'b0, i_box_y} + {1'b0, i_box_h};

    assign w_hit = i_box_en & i_pix_valid
                 & (i_x_pix >= i_box_x) & ({1'b0, i_x_pix} < w_x_end)
                 & (i_y_pix >= i_box_y) & ({1'b0, i_y_pix} < w_y_end);

    always_ff @(posedge clk) begin
        if (i_reset) r_hit <= 1'b0;
        else         r_hit <= w_hit;
    end

    assign o_hit = r_hit;

endmodule

// File: rtl/box_compositor.sv
// N-layer box renderer with double-buffered config and a fixed 2-cycle pixel pipeline.
// Define BOX_COLLISION_EN to build the per-frame box-overlap collision reporter.
module box_compositor
    import box_pkg::*;
#(
    parameter int NUM_BOXES = 4,
    parameter int COORD_W   = BOX_COORD_W,
    parameter int COLOR_W   = BOX_COLOR_W,
    parameter int IDX_W     = (NUM_BOXES > 1) ? $clog2(NUM_BOXES) : 1
) (
    input  logic                 pixel_clk,
    input  logic                 reset,
    input  logic [COORD_W-1:0]   X_pix,
    input  logic [COORD_W-1:0]   Y_pix,
    input  logic                 pix_valid,
    input  logic                 frame_start,
    input  logic [COLOR_W-1:0]   bg_color,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [IDX_W-1:0]     cfg_idx,
    input  logic [COORD_W-1:0]   cfg_x,
    input  logic [COORD_W-1:0]   cfg_y,
    input  logic [COORD_W-1:0]   cfg_w,
    input  logic [COORD_W-1:0]   cfg_h,
    input  logic [COLOR_W-1:0]   cfg_color,
    input  logic                 cfg_en,
    output logic [COLOR_W-1:0]   pixel_color,
    output logic [NUM_BOXES-1:0] hit_mask,
    output logic [NUM_BOXES-1:0] collision_mask,
    output logic                 collision_valid
);

    box_cfg_t               r_shadow [NUM_BOXES];
    box_cfg_t               r_active [NUM_BOXES];
    logic                   w_cfg_wr;
    logic [NUM_BOXES-1:0]   w_hit;
    logic [NUM_BOXES-1:0]   r_hit_s1;
    logic                   r_valid_s1;
    logic [COLOR_W-1:0]     r_bg_s1;
    logic [COLOR_W-1:0]     w_color;
    logic [COLOR_W-1:0]     r_pixel_color;
    logic [NUM_BOXES-1:0]   r_hit_mask;

    // Refusing writes on the frame_start cycle keeps the shadow-to-active copy atomic.
    assign cfg_ready = ~reset & ~frame_start;
    assign w_cfg_wr  = cfg_valid & cfg_ready & (int'(cfg_idx) < NUM_BOXES);

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_BOXES; i++) begin
                r_shadow[i] <= BOX_CFG_RESET;
                r_active[i] <= BOX_CFG_RESET;
            end
        end else begin
            if (w_cfg_wr) begin
                r_shadow[cfg_idx] <= '{x: cfg_x, y: cfg_y, w: cfg_w, h: cfg_h,
                                       color: cfg_color, en: cfg_en};
            end
            if (frame_start) r_active <= r_shadow;
        end
    end

    for (genvar g = 0; g < NUM_BOXES; g++) begin : g_cell
        box_hit_cell #(.COORD_W(COORD_W)) u_cell (
            .clk         (pixel_clk),
            .i_reset     (reset),
            .i_x_pix     (X_pix),
            .i_y_pix     (Y_pix),
            .i_pix_valid (pix_valid),
            .i_box_x     (r_active[g].x),
            .i_box_y     (r_active[g].y),
            .i_box_w     (r_active[g].w),
            .i_box_h     (r_active[g].h),
            .i_box_en    (r_active[g].en),
            .o_hit       (w_hit[g])
        );
    end

    assign r_hit_s1 = w_hit;

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            r_valid_s1 <= 1'b0;
            r_bg_s1    <= '0;
        end else begin
            r_valid_s1 <= pix_valid;
            r_bg_s1    <= bg_color;
        end
    end

    always_comb begin
        w_color = r_bg_s1;
        for (int i = NUM_BOXES - 1; i >= 0; i--) begin
            if (r_hit_s1[i]) w_color = r_active[i].color;
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            r_pixel_color <= '0;
            r_hit_mask    <= '0;
        end else begin
            r_pixel_color <= r_valid_s1 ? w_color : '0;
            r_hit_mask    <= r_hit_s1;
        end
    end

    assign pixel_color = r_pixel_color;
    assign hit_mask    = r_hit_mask;

`ifdef BOX_COLLISION_EN
    logic [NUM_BOXES-1:0] w_contrib;
    logic [NUM_BOXES-1:0] r_accum;
    logic [NUM_BOXES-1:0] r_collision_mask;
    logic                 r_collision_valid;

    // Clearing the lowest set bit leaves something only when two or more boxes hit.
    assign w_contrib = ((r_hit_s1 & (r_hit_s1 - NUM_BOXES'(1))) != '0) ? r_hit_s1 : '0;

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            r_accum           <= '0;
            r_collision_mask  <= '0;
            r_collision_valid <= 1'b0;
        end else begin
            r_collision_valid <= frame_start;
            if (frame_start) begin
                r_collision_mask <= r_accum | w_contrib;
                r_accum          <= '0;
            end else begin
                r_accum <= r_accum | w_contrib;
            end
        end
    end

    assign collision_mask  = r_collision_mask;
    assign collision_valid = r_collision_valid;
`else
    assign collision_mask  = '0;
    assign collision_valid = 1'b0;
`endif

endmodule

// File: tb/tb_box_compositor.sv
// Directed self-checking bench for box_compositor: table of pixel probes plus config/frame/reset sequences.
module tb_box_compositor;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  x_pix, y_pix;
    logic        pix_valid, frame_start;
    logic [11:0] bg_color;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_idx;
    logic [9:0]  cfg_x, cfg_y, cfg_w, cfg_h;
    logic [11:0] cfg_color;
    logic        cfg_en;
    logic [11:0] pixel_color;
    logic [3:0]  hit_mask, collision_mask;
    logic        collision_valid;

    int errors = 0;
    int checks = 0;

`ifdef BOX_COLLISION_EN
    localparam logic COLL = 1'b1;
`else
    localparam logic COLL = 1'b0;
`endif

    localparam logic [11:0] BG = 12'h123;

    always #5 clk = ~clk;

    box_compositor dut (
        .pixel_clk       (clk),
        .reset           (reset),
        .X_pix           (x_pix),
        .Y_pix           (y_pix),
        .pix_valid       (pix_valid),
        .frame_start     (frame_start),
        .bg_color        (bg_color),
        .cfg_valid       (cfg_valid),
        .cfg_ready       (cfg_ready),
        .cfg_idx         (cfg_idx),
        .cfg_x           (cfg_x),
        .cfg_y           (cfg_y),
        .cfg_w           (cfg_w),
        .cfg_h           (cfg_h),
        .cfg_color       (cfg_color),
        .cfg_en          (cfg_en),
        .pixel_color     (pixel_color),
        .hit_mask        (hit_mask),
        .collision_mask  (collision_mask),
        .collision_valid (collision_valid)
    );

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        v;
        logic [11:0] color;
        logic [3:0]  hit;
    } vec_t;

    vec_t tbl[13];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_pix(input string nm, input logic [9:0] x, input logic [9:0] y,
                           input logic v, input logic [11:0] color, input logic [3:0] hit);
        x_pix = x; y_pix = y; pix_valid = v;
        step();
        pix_valid = 1'b0;
        step();
        chk({nm, " color"}, 32'(pixel_color), 32'(color));
        chk({nm, " hit"}, 32'(hit_mask), 32'(hit));
    endtask

    task automatic cfg_write(input logic [1:0] idx, input logic [9:0] x, input logic [9:0] y,
                             input logic [9:0] w, input logic [9:0] h,
                             input logic [11:0] color, input logic en);
        cfg_idx = idx; cfg_x = x; cfg_y = y; cfg_w = w; cfg_h = h;
        cfg_color = color; cfg_en = en; cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic frame();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; x_pix = '0; y_pix = '0; pix_valid = 1'b0; frame_start = 1'b0;
        bg_color = BG; cfg_valid = 1'b0; cfg_idx = '0; cfg_x = '0; cfg_y = '0;
        cfg_w = '0; cfg_h = '0; cfg_color = '0; cfg_en = 1'b0;

        tbl[0]  = '{x: 10'd60,  y: 10'd210, v: 1'b1, color: 12'h0F0, hit: 4'b0001};
        tbl[1]  = '{x: 10'd90,  y: 10'd210, v: 1'b1, color: BG,      hit: 4'b0000};
        tbl[2]  = '{x: 10'd59,  y: 10'd210, v: 1'b1, color: BG,      hit: 4'b0000};
        tbl[3]  = '{x: 10'd89,  y: 10'd329, v: 1'b1, color: 12'h0F0, hit: 4'b0001};
        tbl[4]  = '{x: 10'd89,  y: 10'd330, v: 1'b1, color: BG,      hit: 4'b0000};
        tbl[5]  = '{x: 10'd100, y: 10'd100, v: 1'b1, color: 12'hF00, hit: 4'b0010};
        tbl[6]  = '{x: 10'd119, y: 10'd119, v: 1'b1, color: 12'hF00, hit: 4'b0010};
        tbl[7]  = '{x: 10'd120, y: 10'd119, v: 1'b1, color: BG,      hit: 4'b0000};
        tbl[8]  = '{x: 10'd630, y: 10'd5,   v: 1'b1, color: 12'h00F, hit: 4'b0100};
        tbl[9]  = '{x: 10'd639, y: 10'd479, v: 1'b1, color: 12'h00F, hit: 4'b0100};
        tbl[10] = '{x: 10'd0,   y: 10'd5,   v: 1'b1, color: BG,      hit: 4'b0000};
        tbl[11] = '{x: 10'd9,   y: 10'd5,   v: 1'b1, color: BG,      hit: 4'b0000};
        tbl[12] = '{x: 10'd300, y: 10'd300, v: 1'b1, color: BG,      hit: 4'b0000};

        // Reset state
        step(); step(); step();
        chk("rst pixel_color", 32'(pixel_color), 32'd0);
        chk("rst hit_mask", 32'(hit_mask), 32'd0);
        chk("rst cfg_ready", 32'(cfg_ready), 32'd0);
        chk("rst collision_mask", 32'(collision_mask), 32'd0);
        chk("rst collision_valid", 32'(collision_valid), 32'd0);
        reset = 1'b0;
        #1;
        chk("cfg_ready after reset", 32'(cfg_ready), 32'd1);

        // Phase A: configure, nothing visible until frame_start
        cfg_write(2'd0, 10'd60,  10'd210, 10'd30, 10'd120, 12'h0F0, 1'b1);
        cfg_write(2'd1, 10'd80,  10'd100, 10'd40, 10'd20,  12'hF00, 1'b1);
        cfg_write(2'd2, 10'd630, 10'd0,   10'd20, 10'd480, 12'h00F, 1'b1);
        cfg_write(2'd3, 10'd300, 10'd300, 10'd0,  10'd10,  12'hFFF, 1'b1);
        chk_pix("pre-frame box0", 10'd60, 10'd210, 1'b1, BG, 4'b0000);
        frame();
        chk("frameA coll_valid", 32'(collision_valid), 32'(COLL));
        chk("frameA coll_mask", 32'(collision_mask), 32'd0);
        for (int i = 0; i < 13; i++) begin
            chk_pix($sformatf("tbl[%0d]", i), tbl[i].x, tbl[i].y, tbl[i].v, tbl[i].color, tbl[i].hit);
        end
        chk_pix("invalid in box0", 10'd60, 10'd210, 1'b0, 12'h000, 4'b0000);

        // Phase B: mid-frame write, then a write held across frame_start
        cfg_write(2'd0, 10'd90, 10'd90, 10'd20, 10'd20, 12'h0AA, 1'b1);
        chk_pix("mid-frame unchanged", 10'd100, 10'd100, 1'b1, 12'hF00, 4'b0010);
        cfg_idx = 2'd3; cfg_x = 10'd0; cfg_y = 10'd0; cfg_w = 10'd10; cfg_h = 10'd10;
        cfg_color = 12'hABC; cfg_en = 1'b1; cfg_valid = 1'b1; frame_start = 1'b1;
        #1;
        chk("cfg_ready on frame_start", 32'(cfg_ready), 32'd0);
        step();
        frame_start = 1'b0;
        #1;
        chk("cfg_ready after frame_start", 32'(cfg_ready), 32'd1);
        chk("frameB coll_mask", 32'(collision_mask), 32'd0);
        step();
        cfg_valid = 1'b0;
        chk_pix("late write not yet live", 10'd5, 10'd5, 1'b1, BG, 4'b0000);
        chk_pix("overlap priority", 10'd100, 10'd100, 1'b1, 12'h0AA, 4'b0011);
        chk_pix("box0 only", 10'd95, 10'd95, 1'b1, 12'h0AA, 4'b0001);
        frame();
        chk("frameC coll_valid", 32'(collision_valid), 32'(COLL));
        chk("frameC coll_mask", 32'(collision_mask), COLL ? 32'h3 : 32'h0);
        step();
        chk("coll_valid one cycle", 32'(collision_valid), 32'd0);
        chk_pix("late write live", 10'd5, 10'd5, 1'b1, 12'hABC, 4'b1000);

        // Phase C: invalid pixel inside overlap records no collision
        chk_pix("invalid overlap", 10'd100, 10'd100, 1'b0, 12'h000, 4'b0000);
        frame();
        chk("frameD coll_valid", 32'(collision_valid), 32'(COLL));
        chk("frameD coll_mask", 32'(collision_mask), 32'd0);

        // Phase D: reset mid-frame with an overlap in flight; frame_start under reset ignored
        x_pix = 10'd100; y_pix = 10'd100; pix_valid = 1'b1;
        step();
        reset = 1'b1; frame_start = 1'b1; pix_valid = 1'b0;
        step();
        chk("midrst pixel_color", 32'(pixel_color), 32'd0);
        chk("midrst hit_mask", 32'(hit_mask), 32'd0);
        chk("midrst coll_mask", 32'(collision_mask), 32'd0);
        chk("midrst coll_valid", 32'(collision_valid), 32'd0);
        chk("midrst cfg_ready", 32'(cfg_ready), 32'd0);
        step();
        chk("rst fs ignored coll_valid", 32'(collision_valid), 32'd0);
        frame_start = 1'b0; reset = 1'b0;
        step();
        chk_pix("post-rst bg", 10'd100, 10'd100, 1'b1, BG, 4'b0000);
        frame();
        chk("post-rst frame coll_mask", 32'(collision_mask), 32'd0);
        chk_pix("post-rst frame bg", 10'd100, 10'd100, 1'b1, BG, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/box_compositor.md
# box_compositor

Parametrised N-layer box renderer replacing per-object box drawing and hand-written colour priority in the game top level. Holds NUM_BOXES rectangles (position, size, colour, enable), double-buffered so software/game logic can update them any time while the display only sees new values at frame start. Runs on the VGA pixel clock between the VGA driver's X_pix/Y_pix outputs and its pixel_color input, with a fixed 2-cycle pipeline. Optionally reports per-frame box-overlap collisions for game logic.

## Interface
- NUM_BOXES, 4: number of box layers; index 0 has highest priority.
- COORD_W, 10: width of coordinates and sizes.
- COLOR_W, 12: pixel colour width, packed {B,G,R} 4 bits each.
- IDX_W, $clog2(NUM_BOXES) (min 1): box index width.

- pixel_clk  in  1  pixel clock; sole clock.
- reset  in  1  synchronous, active-high reset.
- X_pix  in  COORD_W  current pixel column.
- Y_pix  in  COORD_W  current pixel row.
- pix_valid  in  1  H_visible & V_visible for current pixel.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- bg_color  in  COLOR_W  colour where no enabled box hits.
- cfg_valid  in  1  config write request.
- cfg_ready  out  1  config write accepted when valid & ready.
- cfg_idx  in  IDX_W  target box.
- cfg_x, cfg_y, cfg_w, cfg_h  in  COORD_W each  top-left corner and size.
- cfg_color  in  COLOR_W  box colour.
- cfg_en  in  1  box visible.
- pixel_color  out  COLOR_W  composited colour, 2 cycles after X_pix/Y_pix.
- hit_mask  out  NUM_BOXES  per-box hit for the pixel on pixel_color.
- collision_mask  out  NUM_BOXES  boxes overlapping another box during last frame.
- collision_valid  out  1  one-cycle pulse when collision_mask updates.

## Operation
- Shadow bank: a write (cfg_valid & cfg_ready) updates shadow[cfg_idx] on that edge; cfg_idx >= NUM_BOXES accepted and discarded.
- Active bank: on frame_start, active <= shadow (all boxes, atomically). Render uses only active.
- cfg_ready = 0 during reset and on the frame_start cycle; 1 otherwise. A write held over frame_start completes the next cycle and lands in the following frame.
- Hit rule per box: en & (X_pix >= x) & (X_pix < x+w) & (Y_pix >= y) & (Y_pix < y+h) & pix_valid. Sums computed at COORD_W+1 bits, no wrap; w=0 or h=0 never hits; boxes extending past the screen edge are clipped, not wrapped.
- Priority: lowest hitting index supplies colour; no hit -> bg_color; pix_valid low -> 0.
- Collision accumulator (NUM_BOXES bits): each stage-2 cycle with two or more hit bits set ORs those bits in. On frame_start: collision_mask <= accum | (current stage-2 contribution), accum <= 0, collision_valid = 1 for that cycle.
- Reset: shadow and active banks all zero (disabled), pipeline cleared, pixel_color = 0, hit_mask = 0, collision_mask = 0, collision_valid = 0, cfg_ready = 0, accum = 0.

## Timing
- Stage 1 (edge 1): registered per-box hit vector, pix_valid, bg_color.
- Stage 2 (edge 2): registered pixel_color, hit_mask; collision accumulate.
- Latency exactly 2 cycles; throughput one pixel per cycle; no stalls.
- Config write to first visible effect: next frame_start edge, then 2 cycles.
- frame_start during reset is ignored.
- Reset mid-frame: all outputs return to reset values on the next edge; the pending collision report is lost.

## Configuration
- BOX_COLLISION_EN defined: accumulator, collision_mask and collision_valid as above.
- Undefined: no accumulator logic; collision_mask and collision_valid tied 0; render path unchanged.

## Structure
- Package box_pkg: box_cfg_t struct {x, y, w, h, color, en}, default COORD_W/COLOR_W constants, BOX_CFG_RESET constant (all zero).
- Sub-module box_hit_cell: one box's registered stage-1 compare; instantiated NUM_BOXES times via generate.

## Test plan
- Reset then box0 = {x=60,y=210,w=30,h=120,color=0x0F0,en=1}, frame_start -> pixel (60,210) gives 0x0F0 two cycles later; (90,210) and (59,210) give bg_color.
- Box0 and box1 overlap at (100,100), frame_start, scan pixel -> pixel_color = box0 colour, hit_mask = 0b0011; after next frame_start with BOX_COLLISION_EN: collision_mask = 0b0011, collision_valid high 1 cycle.
- Write box2 mid-frame -> rendering unchanged until frame_start; cfg_valid on frame_start cycle -> cfg_ready 0, accepted the next cycle, visible only in the frame after.
- Box x=630,w=20 -> hits X_pix 630..639, never X_pix 0..9; w=0 -> never hits.
- pix_valid low inside a box -> pixel_color = 0, hit_mask = 0, no collision recorded.
- Assert reset mid-frame with enabled boxes -> next cycle all outputs 0, then bg_color only after frame_start.
